// File: rtl/eth_gmii_tx.sv
// Ethernet MAC transmit framer: AXI-Stream payload in, GMII out.
// Adds preamble/SFD, zero-pads short frames, appends CRC-32 FCS and holds the inter-frame gap.
module eth_gmii_tx #(
  parameter int IFG_CYCLES      = 12,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       frame_done,
  output logic       frame_err
);

  // Handshake: a payload byte moves when s_axis_tvalid and s_axis_tready are both
  // high at a rising edge of aclk; tready is registered and never depends on tvalid.

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_DROP, S_IFG
  } state_t;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] MIN_LEN  = 32'(MIN_FRAME_BYTES);
  localparam logic [31:0] IFG_LEN  = 32'(IFG_CYCLES);

  state_t      state;
  logic [15:0] cnt;
  logic [10:0] byte_cnt;
  logic [31:0] crc;
  logic [10:0] byte_cnt_inc;
  logic [31:0] fcs;
  logic [7:0]  fcs_byte;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Count saturates; only the pad decision looks at it.
  assign byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign fcs          = ~crc;

  always_comb begin
    fcs_byte = fcs[7:0];
    case (cnt[1:0])
      2'd0:    fcs_byte = fcs[7:0];
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      byte_cnt      <= '0;
      crc           <= CRC_INIT;
      s_axis_tready <= 1'b0;
      gmii_txd      <= 8'h00;
      gmii_tx_en    <= 1'b0;
      gmii_tx_er    <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      gmii_tx_er <= 1'b0;
      case (state)
        S_IDLE: begin
          gmii_tx_en    <= 1'b0;
          gmii_txd      <= 8'h00;
          s_axis_tready <= 1'b0;
          crc           <= CRC_INIT;
          byte_cnt      <= '0;
          cnt           <= '0;
          if (s_axis_tvalid) state <= S_PRE;
        end
        S_PRE: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= 8'h55;
          if (cnt == 16'd6) begin
            cnt   <= '0;
            state <= S_SFD;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SFD: begin
          gmii_tx_en    <= 1'b1;
          gmii_txd      <= 8'hD5;
          s_axis_tready <= 1'b1;
          state         <= S_DATA;
        end
        S_DATA: begin
          if (s_axis_tready && s_axis_tvalid) begin
            gmii_tx_en <= 1'b1;
            gmii_txd   <= s_axis_tdata;
            crc        <= crc_step(crc, s_axis_tdata);
            byte_cnt   <= byte_cnt_inc;
            if (s_axis_tlast) begin
              s_axis_tready <= 1'b0;
              cnt           <= '0;
              state         <= ({21'd0, byte_cnt_inc} < MIN_LEN) ? S_PAD : S_FCS;
            end
          end else if (s_axis_tready) begin
            // Source starved mid-frame: poison the frame on the wire, then discard the rest.
            gmii_tx_en <= 1'b1;
            gmii_tx_er <= 1'b1;
            gmii_txd   <= 8'h00;
            frame_err  <= 1'b1;
            state      <= S_DROP;
          end
        end
        S_PAD: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= 8'h00;
          crc        <= crc_step(crc, 8'h00);
          byte_cnt   <= byte_cnt_inc;
          if ({21'd0, byte_cnt_inc} >= MIN_LEN) begin
            cnt   <= '0;
            state <= S_FCS;
          end
        end
        S_FCS: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= fcs_byte;
          if (cnt[1:0] == 2'd3) begin
            frame_done <= 1'b1;
            cnt        <= '0;
            state      <= S_IFG;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DROP: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (s_axis_tready && s_axis_tvalid && s_axis_tlast) begin
            s_axis_tready <= 1'b0;
            cnt           <= '0;
            state         <= S_IFG;
          end
        end
        S_IFG: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (32'(cnt) + 32'd1 >= IFG_LEN) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/eth_gmii_tx.md
# eth_gmii_tx

Ethernet MAC transmit framer: accepts frame payload (destination MAC through end of payload) as a byte stream and drives the GMII transmit interface. It prepends preamble and SFD, zero-pads short frames, and appends the IEEE 802.3 CRC-32 FCS. It then enforces the inter-frame gap. It is the transmit-side counterpart of the receive CRC checker and produces frames that the checker accepts.

## Interface

Parameters:
- IFG_CYCLES, 12: idle cycles with gmii_tx_en low after the last FCS byte or an abort.
- MIN_FRAME_BYTES, 60: minimum payload+pad byte count before the FCS. 0 disables padding.

Ports:
- aclk  in  1  clock, one byte per cycle (125 MHz GMII).
- areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  8  payload byte.
- s_axis_tvalid  in  1  tdata valid.
- s_axis_tready  out  1  byte accepted on a cycle where tvalid and tready are both high.
- s_axis_tlast  in  1  marks the last payload byte.
- gmii_txd  out  8  GMII transmit data, registered.
- gmii_tx_en  out  1  GMII transmit enable, registered.
- gmii_tx_er  out  1  GMII transmit error, registered.
- frame_done  out  1  one-cycle pulse on the cycle the last FCS byte is driven.
- frame_err  out  1  one-cycle pulse on the cycle gmii_tx_er is driven (underflow abort).

## Operation

- States:
  - IDLE: waits for s_axis_tvalid, then moves to PREAMBLE.
  - PREAMBLE: 7 bytes of 0x55, then SFD.
  - SFD: one byte of 0xD5, then DATA.
  - DATA: on an accepted tlast, moves to PAD if byte_cnt < MIN_FRAME_BYTES, else FCS. On underflow, moves to DROP.
  - PAD: drives 0x00 until byte_cnt = MIN_FRAME_BYTES, then FCS.
  - FCS: drives 4 bytes, then IFG.
  - DROP: tready = 1 and accepted bytes are discarded until tlast is accepted, then IFG.
  - IFG: IFG_CYCLES cycles, then IDLE.
- s_axis_tready is high only in the cycle before each payload byte appears on gmii_txd, and throughout DROP. It is low in IDLE, PREAMBLE, PAD, FCS and IFG.
- Underflow: tready = 1 and tvalid = 0 while in DATA.
  - Next cycle drives gmii_tx_en = 1, gmii_tx_er = 1, gmii_txd = 0x00 and pulses frame_err.
  - Then tx_en drops and the block enters DROP.
  - If the missing beat was the final one, DROP ends as soon as tlast is accepted.
- byte_cnt: 11-bit counter of payload plus pad bytes. It saturates at 2047 and clears in IDLE. Frames longer than 2047 bytes are still transmitted; only the pad decision uses the count.
- CRC:
  - Covers payload and pad bytes only, not preamble or SFD.
  - Initial value 0xFFFFFFFF, reflected polynomial 0xEDB88320, LSB-first per byte.
  - FCS = ~crc, sent as bits [7:0] first, then [15:8], [23:16], [31:24].
  - The CRC register reloads 0xFFFFFFFF in IDLE.
- gmii_txd is 0x00 whenever gmii_tx_en is low.

## Timing

- Reset values: gmii_txd = 0x00, gmii_tx_en = 0, gmii_tx_er = 0, s_axis_tready = 0, frame_done = 0, frame_err = 0. State returns to IDLE and the CRC register to 0xFFFFFFFF.
- Reset asserted mid-frame: every output takes its reset value at the next edge. No FCS is sent and no frame_err pulse is generated.
- Frame start: tvalid sampled high in IDLE at edge k.
  - gmii_tx_en rises after edge k+1, carrying 0x55 for k+1..k+7.
  - 0xD5 is driven after edge k+8.
  - First payload byte is driven after edge k+9.
  - tready is high in the cycle ending at edge k+9 and in each following DATA cycle.
- Payload bytes leave back-to-back with one cycle latency from handshake to gmii_txd.
- A payload of N ≥ MIN_FRAME_BYTES bytes occupies exactly 8 + N + 4 consecutive tx_en cycles with no gaps.
- frame_done is coincident with the 4th FCS byte. tx_en is low on the next cycle.
- IFG: the earliest next frame start (IDLE sampling tvalid) is IFG_CYCLES cycles after tx_en falls. Back-to-back frames therefore have exactly IFG_CYCLES idle cycles between tx_en low and the next tx_en high, plus one sampling cycle.
- tvalid held high during IFG does not shorten the gap.

## Test plan

- MIN_FRAME_BYTES = 0, payload ASCII "123456789" (0x31..0x39) → gmii shows 55×7, D5, 31..39, then FCS 26 39 F4 CB. tx_en high for 21 cycles; frame_done pulses on the CB cycle.
- Default parameters, 1-byte payload 0xAB → AB followed by 59 bytes of 0x00, then 4 FCS bytes. tx_en high for 72 cycles. Receive CRC checker reports valid.
- 64-byte payload 0x00..0x3F → no pad, tx_en high for 76 cycles, FCS matches the software CRC-32 model.
- Underflow: tvalid dropped at payload byte 10 of a 100-byte frame → the cycle after the missed beat shows tx_en = 1, tx_er = 1, txd = 0x00 with a frame_err pulse. Remaining bytes are accepted with tx_en low, then 12 IFG cycles.
- Two 60-byte frames with tvalid held high continuously → exactly 12 cycles of tx_en = 0 between frames, plus one sampling cycle. Both FCS values are correct.
- areset pulsed at payload byte 30 → all outputs 0 on the next edge. A new frame then transmits cleanly with a correct FCS from a fresh CRC.
